// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core.
// Decides each cycle whether IF/ID advance, stall or flush, and whether EX
// receives a bubble or is held. It covers three cases: load-use hazards,
// taken-branch redirects and multi-cycle EX operations.
// Control outputs are Mealy (combinational from the current state and inputs).
// State, the performance counters and the sticky timeout flag are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_LEN    = 2,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             rf_wr_en_EX,
  input  logic [2:0]       dm_rd_ctrl_EX,
  input  logic             branch_taken_EX,
  input  logic             ex_busy,
  input  logic             ex_done,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic             bubble_EX,
  output logic             hold_EX,
  output logic             redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             err_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_BUSY  = 2'b10
  } state_e;

  // The branch cycle itself is the first squash cycle, so FLUSH holds the rest.
  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_LEN - 1);
  localparam logic [7:0]       BUSY_LIMIT   = 8'(BUSY_TIMEOUT);
  localparam logic [7:0]       BUSY_SAT     = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);

  state_e     state_r;
  state_e     state_next_s;
  logic [2:0] flush_cnt_r;
  logic [2:0] flush_cnt_next_s;
  logic [7:0] busy_cnt_r;
  logic [7:0] busy_cnt_next_s;
  logic       err_set_s;
  logic       load_use_s;

  // Detect a load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_s = (dm_rd_ctrl_EX != 3'd0) && rf_wr_en_EX && (rd_EX != 5'd0) &&
                 ((use_rs1_ID && (rd_EX == rs1_ID)) || (use_rs2_ID && (rd_EX == rs2_ID)));
  end

  // Next-state and Mealy control decode; everything is forced idle while in reset.
  always_comb begin
    stall_IF         = 1'b0;
    stall_ID         = 1'b0;
    flush_ID         = 1'b0;
    bubble_EX        = 1'b0;
    hold_EX          = 1'b0;
    redirect         = 1'b0;
    err_set_s        = 1'b0;
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    busy_cnt_next_s  = busy_cnt_r;
    if (!reset) begin
      state_next_s     = ST_RUN;
      flush_cnt_next_s = 3'd0;
      busy_cnt_next_s  = 8'd0;
    end else begin
      case (state_r)
        ST_FLUSH: begin
          // Squashed instructions cannot raise hazards; only a new branch matters.
          flush_ID  = 1'b1;
          bubble_EX = 1'b1;
          if (branch_taken_EX) begin
            redirect         = 1'b1;
            flush_cnt_next_s = FLUSH_RELOAD;
            if (FLUSH_RELOAD == 3'd0) begin
              state_next_s = ST_RUN;
            end else begin
              state_next_s = ST_FLUSH;
            end
          end else if (flush_cnt_r <= 3'd1) begin
            flush_cnt_next_s = 3'd0;
            state_next_s     = ST_RUN;
          end else begin
            flush_cnt_next_s = flush_cnt_r - 3'd1;
            state_next_s     = ST_FLUSH;
          end
        end
        ST_BUSY: begin
          // Hold the front end until the multi-cycle result arrives.
          if (ex_done) begin
            state_next_s    = ST_RUN;
            busy_cnt_next_s = 8'd0;
          end else begin
            stall_IF     = 1'b1;
            stall_ID     = 1'b1;
            hold_EX      = 1'b1;
            state_next_s = ST_BUSY;
            if (busy_cnt_r == BUSY_LIMIT) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = 1'b0;
            end
            if (busy_cnt_r != BUSY_SAT) begin
              busy_cnt_next_s = busy_cnt_r + 8'd1;
            end else begin
              busy_cnt_next_s = busy_cnt_r;
            end
          end
        end
        default: begin
          // RUN, and the unused encoding 11 which behaves exactly like RUN.
          if (branch_taken_EX) begin
            redirect  = 1'b1;
            flush_ID  = 1'b1;
            bubble_EX = 1'b1;
            if (FLUSH_RELOAD != 3'd0) begin
              state_next_s     = ST_FLUSH;
              flush_cnt_next_s = FLUSH_RELOAD;
            end else begin
              state_next_s     = ST_RUN;
              flush_cnt_next_s = 3'd0;
            end
          end else if (ex_busy) begin
            stall_IF        = 1'b1;
            stall_ID        = 1'b1;
            hold_EX         = 1'b1;
            state_next_s    = ST_BUSY;
            busy_cnt_next_s = 8'd1;
          end else if (load_use_s) begin
            // One bubble suffices: the load moves to MEM and forwarding covers the rest.
            stall_IF     = 1'b1;
            stall_ID     = 1'b1;
            bubble_EX    = 1'b1;
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      endcase
    end
  end

  // State and sequencing counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
      busy_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      flush_cnt_r <= flush_cnt_next_s;
      busy_cnt_r  <= busy_cnt_next_s;
    end
  end

  // Saturating performance counters for stall cycles and redirects.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_IF && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (redirect && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + CNT_ONE;
      end else begin
        flush_events <= flush_events;
      end
    end
  end

  // Sticky busy-timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= err_timeout | err_set_s;
    end
  end

  assign state_o = state_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// random traffic, all checked cycle by cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FLUSH_LEN    = 2;
  localparam int unsigned BUSY_TIMEOUT = 5;
  localparam int unsigned CNT_W        = 32;
  localparam longint      CNT_SAT      = (64'sd1 <<< CNT_W) - 64'sd1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs1_ID, rs2_ID, rd_EX;
  logic             use_rs1_ID, use_rs2_ID, rf_wr_en_EX;
  logic [2:0]       dm_rd_ctrl_EX;
  logic             branch_taken_EX, ex_busy, ex_done;
  logic             stall_IF, stall_ID, flush_ID, bubble_EX, hold_EX, redirect;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic             err_timeout;

  int checks   = 0;
  int failures = 0;

  // Model: remaining squash cycles, whether a long op is outstanding, and its age.
  int     m_flush_left = 0;
  bit     m_busy       = 1'b0;
  int     m_busy_age   = 0;
  bit     m_err        = 1'b0;
  longint m_stalls     = 0;
  longint m_redirects  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FLUSH_LEN(FLUSH_LEN),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .rf_wr_en_EX(rf_wr_en_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX),
    .branch_taken_EX(branch_taken_EX), .ex_busy(ex_busy), .ex_done(ex_done),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .bubble_EX(bubble_EX), .hold_EX(hold_EX), .redirect(redirect),
    .state_o(state_o), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .err_timeout(err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, then advance the model.
  task automatic step(input logic rst, input logic br, input logic bsy, input logic dn,
                      input logic [2:0] dm, input logic wr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2);
    bit lu, e_stall, e_flush, e_bubble, e_hold, e_redir;
    int e_state;
    @(negedge clk);
    reset = rst; branch_taken_EX = br; ex_busy = bsy; ex_done = dn;
    dm_rd_ctrl_EX = dm; rf_wr_en_EX = wr; rd_EX = rd;
    rs1_ID = r1; rs2_ID = r2; use_rs1_ID = u1; use_rs2_ID = u2;
    #1;
    lu = (dm != 3'd0) && wr && (rd != 5'd0) && ((u1 && rd == r1) || (u2 && rd == r2));
    e_stall = 0; e_flush = 0; e_bubble = 0; e_hold = 0; e_redir = 0;
    e_state = m_busy ? 2 : ((m_flush_left > 0) ? 1 : 0);
    if (rst) begin
      if (m_busy) begin
        if (!dn) begin e_stall = 1; e_hold = 1; end
      end else if (m_flush_left > 0) begin
        e_flush = 1; e_bubble = 1; e_redir = br;
      end else if (br) begin
        e_redir = 1; e_flush = 1; e_bubble = 1;
      end else if (bsy) begin
        e_stall = 1; e_hold = 1;
      end else if (lu) begin
        e_stall = 1; e_bubble = 1;
      end
    end
    check_eq("stall_IF", 32'(stall_IF), 32'(e_stall));
    check_eq("stall_ID", 32'(stall_ID), 32'(e_stall));
    check_eq("flush_ID", 32'(flush_ID), 32'(e_flush));
    check_eq("bubble_EX", 32'(bubble_EX), 32'(e_bubble));
    check_eq("hold_EX", 32'(hold_EX), 32'(e_hold));
    check_eq("redirect", 32'(redirect), 32'(e_redir));
    check_eq("state_o", 32'(state_o), 32'(e_state));
    check_eq("stall_cycles", stall_cycles, 32'(m_stalls));
    check_eq("flush_events", flush_events, 32'(m_redirects));
    check_eq("err_timeout", 32'(err_timeout), 32'(m_err));
    if (!rst) begin
      m_flush_left = 0; m_busy = 0; m_busy_age = 0; m_err = 0;
      m_stalls = 0; m_redirects = 0;
    end else begin
      if (e_stall && m_stalls < CNT_SAT) m_stalls++;
      if (e_redir && m_redirects < CNT_SAT) m_redirects++;
      if (m_busy) begin
        if (dn) m_busy = 0;
        else begin
          if (m_busy_age == int'(BUSY_TIMEOUT)) m_err = 1;
          if (m_busy_age < 255) m_busy_age++;
        end
      end else if (m_flush_left > 0) begin
        m_flush_left = br ? int'(FLUSH_LEN) - 1 : m_flush_left - 1;
      end else if (br) begin
        m_flush_left = int'(FLUSH_LEN) - 1;
      end else if (bsy) begin
        m_busy = 1; m_busy_age = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; branch_taken_EX = 1'b0; ex_busy = 1'b0; ex_done = 1'b0;
    dm_rd_ctrl_EX = 3'd0; rf_wr_en_EX = 1'b0; rd_EX = 5'd0;
    rs1_ID = 5'd0; rs2_ID = 5'd0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;

    // Reset then quiet pipeline.
    do_reset(3);
    idle(10);
    check_eq("idle_state", 32'(state_o), 32'd0);
    check_eq("idle_stalls", stall_cycles, 32'd0);
    check_eq("idle_flushes", flush_events, 32'd0);

    // Load-use on rs1, then the same with rd_EX = x0 (no hazard).
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    idle(1);
    check_eq("lu_stalls", stall_cycles, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(1);
    check_eq("lu_x0_stalls", stall_cycles, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1);
    idle(1);
    check_eq("lu_rs2_stalls", stall_cycles, 32'd2);

    // Single branch, then a branch repeated inside the flush window.
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("br_flush_state", 32'(state_o), 32'd0);
    idle(1);
    check_eq("br_in_flush", 32'(state_o), 32'd1);
    idle(1);
    check_eq("br_events", flush_events, 32'd1);
    check_eq("br_back_run", 32'(state_o), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(2);
    check_eq("br2_events", flush_events, 32'd3);

    // Branch, busy and load-use together: branch has priority.
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    idle(1);
    check_eq("prio_state", 32'(state_o), 32'd1);
    check_eq("prio_stalls", stall_cycles, 32'd2);
    idle(2);

    // Multi-cycle op finishing before the timeout.
    do_reset(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(1);
    check_eq("busy_stalls", stall_cycles, 32'd5);
    check_eq("busy_no_err", 32'(err_timeout), 32'd0);
    check_eq("busy_done_run", 32'(state_o), 32'd0);

    // Timeout: sticky through ex_done, cleared only by reset.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(6);
    check_eq("tmo_err", 32'(err_timeout), 32'd1);
    check_eq("tmo_state", 32'(state_o), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(1);
    check_eq("tmo_sticky", 32'(err_timeout), 32'd1);
    do_reset(1);
    idle(1);
    check_eq("tmo_cleared", 32'(err_timeout), 32'd0);

    // Reset in the first BUSY cycle aborts to RUN.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    do_reset(1);
    idle(1);
    check_eq("rst_busy_state", 32'(state_o), 32'd0);
    check_eq("rst_busy_stalls", stall_cycles, 32'd0);

    // Random traffic with small register indices to provoke hazards often.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
